// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_EN_W  = 4;
    // Widest request address the responder can carry internally; ADDR_W must not exceed it.
    localparam int REQ_ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic                  write;
        logic [REQ_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [BYTE_EN_W-1:0]  byteen;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: byte-enabled synchronous write, combinational read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [BYTE_EN_W-1:0]           byteen,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTE_EN_W; b++) begin
                if (byteen[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the load/store channel: one request at a time, WAIT_CYCLES
// wait states, then a read-data or write-ack response held until accepted.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_ReqValid,
    output logic              o_ReqReady,
    input  logic              i_ReqWrite,
    input  logic [ADDR_W-1:0] i_ReqAddr,
    input  logic [31:0]       i_ReqWData,
    input  logic [3:0]        i_ReqByteEn,
    output logic              o_RspValid,
    input  logic              i_RspReady,
    output logic [31:0]       o_RspRData,
    output logic              o_RspErr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    dmem_req_t        cur_req;
    logic             req_hs;
    logic             commit;
    logic             cur_err;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      mem_rdata;

    assign o_ReqReady = (state_q == IDLE) && i_Reset;
    assign req_hs     = i_ReqValid && o_ReqReady;

    // With zero wait states the access commits on the accept edge itself,
    // so the live request inputs must feed the RAM and error check while idle.
    always_comb begin
        cur_req = req_q;
        if (state_q == IDLE) begin
            cur_req.write  = i_ReqWrite;
            cur_req.addr   = REQ_ADDR_W'(i_ReqAddr);
            cur_req.wdata  = i_ReqWData;
            cur_req.byteen = i_ReqByteEn;
        end
    end

    assign cur_err = (cur_req.addr[1:0] != 2'b00)
                  || (cur_req.addr[REQ_ADDR_W-1:IDX_W+2] != '0);
    assign mem_idx = cur_req.addr[IDX_W+1:2];
    assign mem_we  = commit && cur_req.write && !cur_err;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (i_Clk),
        .we     (mem_we),
        .addr   (mem_idx),
        .byteen (cur_req.byteen),
        .wdata  (cur_req.wdata),
        .rdata  (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    req_d = cur_req;
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_RspReady) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            err_d   = cur_err;
            rdata_d = (!cur_req.write && !cur_err) ? mem_rdata : '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign o_RspValid = (state_q == RESP);
    assign o_RspRData = rdata_q;
    assign o_RspErr   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a two-wait-state responder for the main scenarios and a
// zero-wait-state responder for back-to-back throughput.
module tb_dmem_responder;

    localparam int TB_WAIT  = 2;
    localparam int TB_DEPTH = 256;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_write0;
    logic [31:0] req_addr0, req_wdata0;
    logic [3:0]  req_be0;
    logic        rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int          n_vec;
    int          n_err;
    exp_t        sb_q[$];
    exp_t        sb0_q[$];
    logic [31:0] model_mem [TB_DEPTH];

    dmem_responder #(
        .ADDR_W(32), .DEPTH_WORDS(TB_DEPTH), .WAIT_CYCLES(TB_WAIT)
    ) u_dut (
        .i_Clk(clk), .i_Reset(rst_n),
        .i_ReqValid(req_valid), .o_ReqReady(req_ready), .i_ReqWrite(req_write),
        .i_ReqAddr(req_addr), .i_ReqWData(req_wdata), .i_ReqByteEn(req_be),
        .o_RspValid(rsp_valid), .i_RspReady(rsp_ready),
        .o_RspRData(rsp_rdata), .o_RspErr(rsp_err)
    );

    dmem_responder #(
        .ADDR_W(32), .DEPTH_WORDS(TB_DEPTH), .WAIT_CYCLES(0)
    ) u_dut0 (
        .i_Clk(clk), .i_Reset(rst_n),
        .i_ReqValid(req_valid0), .o_ReqReady(req_ready0), .i_ReqWrite(req_write0),
        .i_ReqAddr(req_addr0), .i_ReqWData(req_wdata0), .i_ReqByteEn(req_be0),
        .o_RspValid(rsp_valid0), .i_RspReady(rsp_ready0),
        .o_RspRData(rsp_rdata0), .o_RspErr(rsp_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference behaviour: error rule, full-word load, per-lane store.
    task automatic model_access(input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output exp_t e);
        logic       err;
        logic [7:0] idx;
        err     = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(TB_DEPTH));
        idx     = addr[9:2];
        e.err   = err;
        e.rdata = 32'h0;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.rdata = model_mem[idx];
            end
        end
    endtask

    task automatic do_txn(input string name, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold);
        exp_t e;
        int   waitc;
        int   lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL %s accept: got ReqReady=%b, expected 1", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        model_access(wr, addr, wdata, be, e);
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== TB_WAIT + 1) begin
            n_err++;
            $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, lat, TB_WAIT + 1);
        end
        e = sb_q.pop_front();
        if (rsp_valid !== 1'b1) return;
        n_vec++;
        if (rsp_rdata !== e.rdata) begin
            n_err++;
            $display("[TB] FAIL %s rdata: got %h, expected %h", name, rsp_rdata, e.rdata);
        end
        n_vec++;
        if (rsp_err !== e.err) begin
            n_err++;
            $display("[TB] FAIL %s err: got %b, expected %b", name, rsp_err, e.err);
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, e.err, e.rdata}) begin
                n_err++;
                $display("[TB] FAIL %s hold%0d: got valid=%b ready=%b err=%b rdata=%h, expected 1 0 %b %h",
                         name, h, rsp_valid, req_ready, rsp_err, rsp_rdata, e.err, e.rdata);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            n_err++;
            $display("[TB] FAIL %s release: got valid=%b ready=%b err=%b rdata=%h, expected 0 1 0 0",
                     name, rsp_valid, req_ready, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, req_ready0} !== {1'b0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL reset_state: got ready=%b valid=%b err=%b rdata=%h ready0=%b, expected 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, req_ready0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({req_ready, rsp_valid, req_ready0} !== 3'b101) begin
            n_err++;
            $display("[TB] FAIL reset_release: got ready=%b valid=%b ready0=%b, expected 1 0 1",
                     req_ready, rsp_valid, req_ready0);
        end
    endtask

    task automatic test_store_load();
        do_txn("store_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0);
        do_txn("load_10",  1'b0, 32'h10, 32'h0,        4'b1111, 0);
    endtask

    task automatic test_byte_lanes();
        do_txn("init_20",    1'b1, 32'h20, 32'h11223344, 4'b1111, 0);
        do_txn("lane0_20",   1'b1, 32'h20, 32'h000000AA, 4'b0001, 0);
        do_txn("lane1_20",   1'b1, 32'h20, 32'h0000BB00, 4'b0010, 0);
        do_txn("load_20",    1'b0, 32'h20, 32'h0,        4'b0000, 0);
        do_txn("nolane_20",  1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0);
        do_txn("reload_20",  1'b0, 32'h20, 32'h0,        4'b1111, 0);
    endtask

    task automatic test_errors();
        do_txn("init_0",     1'b1, 32'h0,   32'h01020304, 4'b1111, 0);
        do_txn("misalign",   1'b0, 32'h22,  32'h0,        4'b1111, 0);
        do_txn("oob_store",  1'b1, 32'(4 * TB_DEPTH), 32'hFFFFFFFF, 4'b1111, 0);
        do_txn("load_0",     1'b0, 32'h0,   32'h0,        4'b1111, 0);
        do_txn("mis_store",  1'b1, 32'h3,   32'hFFFFFFFF, 4'b1111, 0);
        do_txn("reload_0",   1'b0, 32'h0,   32'h0,        4'b1111, 0);
    endtask

    task automatic test_backpressure();
        do_txn("bp_load_10", 1'b0, 32'h10, 32'h0, 4'b1111, 5);
    endtask

    task automatic test_reset_in_wait();
        int waitc;
        do_txn("init_30", 1'b1, 32'h30, 32'h0, 4'b1111, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'b1111;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, req_ready} !== 2'b00) begin
                n_err++;
                $display("[TB] FAIL rst_wait%0d: got valid=%b ready=%b, expected 0 0", c, rsp_valid, req_ready);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL rst_wait_release: got valid=%b ready=%b, expected 0 1", rsp_valid, req_ready);
        end
        do_txn("load_30", 1'b0, 32'h30, 32'h0, 4'b1111, 0);
    endtask

    // Zero wait states with RspReady tied high: accept and respond on alternate cycles.
    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            req_valid0 = 1'b1;
            req_write0 = (i < 4);
            req_addr0  = 32'(4 * (i % 4));
            req_wdata0 = 32'hA5000000 | 32'(i);
            req_be0    = 4'b1111;
            n_vec++;
            if ({req_ready0, rsp_valid0} !== 2'b10) begin
                n_err++;
                $display("[TB] FAIL b2b_accept%0d: got ready=%b valid=%b, expected 1 0", i, req_ready0, rsp_valid0);
            end
            e.err   = 1'b0;
            e.rdata = (i < 4) ? 32'h0 : (32'hA5000000 | 32'(i - 4));
            sb0_q.push_back(e);
            @(negedge clk);
            e = sb0_q.pop_front();
            n_vec++;
            if ({rsp_valid0, req_ready0, rsp_err0, rsp_rdata0} !== {1'b1, 1'b0, e.err, e.rdata}) begin
                n_err++;
                $display("[TB] FAIL b2b_resp%0d: got valid=%b ready=%b err=%b rdata=%h, expected 1 0 %b %h",
                         i, rsp_valid0, req_ready0, rsp_err0, rsp_rdata0, e.err, e.rdata);
            end
            req_valid0 = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if ({rsp_valid0, req_ready0} !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL b2b_idle: got valid=%b ready=%b, expected 0 1", rsp_valid0, req_ready0);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_be     = 4'h0;
        rsp_ready  = 1'b0;
        req_valid0 = 1'b0;
        req_write0 = 1'b0;
        req_addr0  = 32'h0;
        req_wdata0 = 32'h0;
        req_be0    = 4'h0;
        rsp_ready0 = 1'b1;
        for (int i = 0; i < TB_DEPTH; i++) model_mem[i] = 32'h0;
        #2 rst_n = 1'b0;

        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the load/store request/response interface that the pipelined processor drives as initiator.
- Accepts one request at a time over a valid/ready channel and inserts a configurable number of wait states.
- Returns the read data or a write acknowledge over a valid/ready response channel.
- Serves as the stall-capable memory model for processor benches and as the synthesizable tightly-coupled data RAM.

Parameters:
ADDR_W, 32, request address width in bits
DEPTH_WORDS, 256, number of 32-bit words; must be a power of two, minimum 4
WAIT_CYCLES, 2, wait states inserted between request accept and response; legal range 0..15

Ports:
i_Clk  in  1  clock; all state changes on its rising edge
i_Reset  in  1  asynchronous, active-low reset
i_ReqValid  in  1  request present
o_ReqReady  out  1  responder can accept a request this cycle
i_ReqWrite  in  1  1 = store, 0 = load
i_ReqAddr  in  ADDR_W  byte address
i_ReqWData  in  32  store data
i_ReqByteEn  in  4  store byte lanes; bit n enables byte n, i.e. bits [8n+7:8n]
o_RspValid  out  1  response present
i_RspReady  in  1  initiator accepts the response
o_RspRData  out  32  load data; 0 for stores and for errors
o_RspErr  out  1  misaligned or out-of-range access

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset puts the FSM in IDLE, clears the wait counter, and drives o_RspValid=0, o_RspRData=0, o_RspErr=0.
- o_ReqReady = (state==IDLE) && i_Reset, so it is 0 while reset is asserted.
- IDLE: a handshake (i_ReqValid && o_ReqReady) latches i_ReqWrite, i_ReqAddr, i_ReqWData and i_ReqByteEn.
  - If WAIT_CYCLES==0, next state is RESP.
  - Otherwise the counter loads WAIT_CYCLES and the next state is WAIT.
  - With no handshake the FSM stays in IDLE.
- WAIT: the counter decrements each cycle. On the edge where it reaches 0, the state moves to RESP. Request inputs are ignored and o_ReqReady=0.
- Access commit happens on the edge that enters RESP:
  - Error check: err = (addr[1:0]!=0) || (addr[ADDR_W-1:2] >= DEPTH_WORDS).
  - Load, no error: o_RspRData = mem[addr[log2(DEPTH_WORDS)+1:2]]. The full word is returned and ByteEn is ignored.
  - Store, no error: each enabled byte lane is written; o_RspRData=0. ByteEn=0000 is legal: no change, no error.
  - Error: no memory write, o_RspRData=0, o_RspErr=1.
- RESP: o_RspValid=1. o_RspRData and o_RspErr are held stable until i_RspReady=1. On that edge the state returns to IDLE and o_RspValid, o_RspRData and o_RspErr clear to 0.
- Latency: the response is visible WAIT_CYCLES+1 cycles after the accept edge.
- Throughput: at most one request outstanding. The earliest next accept is the cycle after response acceptance, so the best case is one transaction per WAIT_CYCLES+2 cycles.
- Read-after-write: a load issued after a store has completed returns the updated bytes.
- Memory contents are not reset. The bench preloads them by hierarchical write or $readmemh.
- Reset mid-operation:
  - In WAIT, the pending access is discarded and a pending store is never committed.
  - In RESP, the response is dropped; a store already committed stays committed.
  - After reset release, the FSM is in IDLE with o_ReqReady=1.
- Back-pressure: i_RspReady held low keeps the FSM in RESP indefinitely. i_RspReady high outside RESP has no effect.

Decomposition:
- Package dmem_pkg holds:
  - enum dmem_state_t {IDLE, WAIT, RESP}
  - struct dmem_req_t {write, addr, wdata, byteen}
  - constants WORD_BYTES=4 and BYTE_EN_W=4
- Sub-module dmem_array: a single-port, byte-enabled, synchronous-write, combinational-read word RAM with parameter DEPTH_WORDS. The FSM and error logic stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=2: store addr 0x10, data 0xDEADBEEF, ByteEn 1111, then load 0x10 -> response 3 cycles after each accept, RData=0xDEADBEEF, Err=0.
- Over word 0x11223344 at addr 0x20: store data 0x000000AA with ByteEn 0001, then 0x0000BB00 with ByteEn 0010, then load -> RData=0x1122BBAA.
- Load addr 0x22 (misaligned) -> Err=1, RData=0. Store to addr 4*DEPTH_WORDS -> Err=1 and a follow-up load of word 0 is unchanged.
- Hold i_RspReady=0 for 5 cycles in RESP -> o_RspValid, RData and Err stay stable and o_ReqReady=0 throughout. Raise i_RspReady -> next cycle IDLE with o_ReqReady=1.
- WAIT_CYCLES=0: back-to-back loads with i_RspReady tied high -> accept, response the next cycle, accept again; one transaction every 2 cycles.
- Assert i_Reset low during WAIT of a store to 0x30 (word initially 0x0) -> o_RspValid stays 0 and a load of 0x30 after release returns 0x00000000.
